// File: rtl/cpu_ctrl_seq_if.sv
// Control bundle between the sequencer (master) and the datapath (slave); the step input exists only under CTRL_SINGLE_STEP_EN.
interface cpu_ctrl_seq_if;
    logic [7:0] ir;
    logic       flag_c;
    logic       flag_z;
`ifdef CTRL_SINGLE_STEP_EN
    logic       step;
`endif
    logic [2:0] bus_sel;
    logic       pc_l;
    logic       mar_l;
    logic       ir_l;
    logic       a_l;
    logic       b_l;
    logic       out_l;
    logic       flags_l;
    logic       pc_inc;
    logic       mem_we;
    logic       alu_sub;
    logic       halted;

    modport master (
        input  ir, flag_c, flag_z,
`ifdef CTRL_SINGLE_STEP_EN
        input  step,
`endif
        output bus_sel, pc_l, mar_l, ir_l, a_l, b_l, out_l, flags_l,
        output pc_inc, mem_we, alu_sub, halted
    );

    modport slave (
        output ir, flag_c, flag_z,
`ifdef CTRL_SINGLE_STEP_EN
        output step,
`endif
        input  bus_sel, pc_l, mar_l, ir_l, a_l, b_l, out_l, flags_l,
        input  pc_inc, mem_we, alu_sub, halted
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Fetch/execute control sequencer for the 8-bit CPU: outputs decode state, opcode and flags combinationally.
// CTRL_SINGLE_STEP_EN: F0 waits for step=1 before fetching; otherwise the sequencer free-runs.
module cpu_ctrl_seq #(
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    cpu_ctrl_seq_if.master bus
);

    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        E0   = 3'd2,
        E1   = 3'd3,
        E2   = 3'd4,
        HALT = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] opc;

    logic [2:0] bus_sel;
    logic       pc_l, mar_l, ir_l, a_l, b_l, out_l, flags_l;
    logic       pc_inc, mem_we, alu_sub, halted;

    // Operand bits are consumed by the datapath, not here.
    logic unused_opnd;
    assign unused_opnd = ^{bus.ir[3:0], (ADDR_W >= 1 && ADDR_W <= 4)};

    assign opc = bus.ir[7:4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= F0;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = F0;
        bus_sel   = 3'd0;
        pc_l      = 1'b0;
        mar_l     = 1'b0;
        ir_l      = 1'b0;
        a_l       = 1'b0;
        b_l       = 1'b0;
        out_l     = 1'b0;
        flags_l   = 1'b0;
        pc_inc    = 1'b0;
        mem_we    = 1'b0;
        alu_sub   = 1'b0;
        halted    = 1'b0;

        case (state)
            F0: begin
`ifdef CTRL_SINGLE_STEP_EN
                // While waiting for step nothing is driven, so MAR holds.
                if (bus.step) begin
                    bus_sel   = 3'd1;
                    mar_l     = 1'b1;
                    state_nxt = F1;
                end else begin
                    state_nxt = F0;
                end
`else
                bus_sel   = 3'd1;
                mar_l     = 1'b1;
                state_nxt = F1;
`endif
            end
            F1: begin
                bus_sel   = 3'd2;
                ir_l      = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = E0;
            end
            E0: begin
                case (opc)
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        bus_sel   = 3'd3;
                        mar_l     = 1'b1;
                        state_nxt = E1;
                    end
                    4'h5: begin
                        bus_sel = 3'd3;
                        a_l     = 1'b1;
                    end
                    4'h6: begin
                        bus_sel = 3'd3;
                        pc_l    = 1'b1;
                    end
                    4'h7: begin
                        bus_sel = 3'd3;
                        pc_l    = bus.flag_c;
                    end
                    4'h8: begin
                        bus_sel = 3'd3;
                        pc_l    = bus.flag_z;
                    end
                    4'hE: begin
                        bus_sel = 3'd4;
                        out_l   = 1'b1;
                    end
                    4'hF:    state_nxt = HALT;
                    default: state_nxt = F0;
                endcase
            end
            E1: begin
                case (opc)
                    4'h1: begin
                        bus_sel = 3'd2;
                        a_l     = 1'b1;
                    end
                    4'h2, 4'h3: begin
                        bus_sel   = 3'd2;
                        b_l       = 1'b1;
                        state_nxt = E2;
                    end
                    4'h4: begin
                        bus_sel = 3'd4;
                        mem_we  = 1'b1;
                    end
                    default: state_nxt = F0;
                endcase
            end
            E2: begin
                if (opc == 4'h2 || opc == 4'h3) begin
                    bus_sel = 3'd5;
                    a_l     = 1'b1;
                    flags_l = 1'b1;
                    alu_sub = (opc == 4'h3);
                end
            end
            HALT: begin
                halted    = 1'b1;
                state_nxt = HALT;
            end
            default: state_nxt = F0;
        endcase
    end

    assign bus.bus_sel = bus_sel;
    assign bus.pc_l    = pc_l;
    assign bus.mar_l   = mar_l;
    assign bus.ir_l    = ir_l;
    assign bus.a_l     = a_l;
    assign bus.b_l     = b_l;
    assign bus.out_l   = out_l;
    assign bus.flags_l = flags_l;
    assign bus.pc_inc  = pc_inc;
    assign bus.mem_we  = mem_we;
    assign bus.alu_sub = alu_sub;
    assign bus.halted  = halted;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: each instruction is expanded into its expected per-cycle control vectors.
module tb_cpu_ctrl_seq;

    typedef struct packed {
        logic [2:0] bus_sel;
        logic       pc_l, mar_l, ir_l, a_l, b_l, out_l, flags_l;
        logic       pc_inc, mem_we, alu_sub, halted;
    } ctl_t;

    localparam logic [10:0] PC_L    = 11'h400;
    localparam logic [10:0] MAR_L   = 11'h200;
    localparam logic [10:0] IR_L    = 11'h100;
    localparam logic [10:0] A_L     = 11'h080;
    localparam logic [10:0] B_L     = 11'h040;
    localparam logic [10:0] OUT_L   = 11'h020;
    localparam logic [10:0] FLAGS_L = 11'h010;
    localparam logic [10:0] PC_INC  = 11'h008;
    localparam logic [10:0] MEM_WE  = 11'h004;
    localparam logic [10:0] ALU_SUB = 11'h002;
    localparam logic [10:0] HALTED  = 11'h001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_ctrl_seq_if bus_if ();
    cpu_ctrl_seq #(.ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int   errors = 0;
    int   checks = 0;
    ctl_t exp_q[$];

    function automatic ctl_t mk(input int bsel, input logic [10:0] en);
        logic [2:0] b;
        b  = bsel[2:0];
        mk = {b, en};
    endfunction

    function automatic ctl_t observed();
        observed = {bus_if.bus_sel, bus_if.pc_l, bus_if.mar_l, bus_if.ir_l, bus_if.a_l,
                    bus_if.b_l, bus_if.out_l, bus_if.flags_l, bus_if.pc_inc,
                    bus_if.mem_we, bus_if.alu_sub, bus_if.halted};
    endfunction

    // Reference: the instruction table as a list of per-cycle control vectors.
    task automatic build_expect(input logic [7:0] instr, input logic c, input logic z);
        logic [3:0] op;
        op = instr[7:4];
        exp_q = {};
        exp_q.push_back(mk(1, MAR_L));
        exp_q.push_back(mk(2, IR_L | PC_INC));
        case (op)
            4'h1: begin exp_q.push_back(mk(3, MAR_L)); exp_q.push_back(mk(2, A_L)); end
            4'h2, 4'h3: begin
                exp_q.push_back(mk(3, MAR_L));
                exp_q.push_back(mk(2, B_L));
                exp_q.push_back(mk(5, A_L | FLAGS_L | ((op == 4'h3) ? ALU_SUB : 11'h0)));
            end
            4'h4: begin exp_q.push_back(mk(3, MAR_L)); exp_q.push_back(mk(4, MEM_WE)); end
            4'h5: exp_q.push_back(mk(3, A_L));
            4'h6: exp_q.push_back(mk(3, PC_L));
            4'h7: exp_q.push_back(mk(3, c ? PC_L : 11'h0));
            4'h8: exp_q.push_back(mk(3, z ? PC_L : 11'h0));
            4'hE: exp_q.push_back(mk(4, OUT_L));
            default: exp_q.push_back(mk(0, 11'h0));
        endcase
    endtask

    // Entered and left at a falling edge with the sequencer in F0.
    task automatic run_instr(input logic [7:0] instr, input logic c, input logic z);
        ctl_t obs;
        bus_if.ir     = instr;
        bus_if.flag_c = c;
        bus_if.flag_z = z;
        build_expect(instr, c, z);
        foreach (exp_q[i]) begin
            #1;
            obs = observed();
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL instr_%02h_step%0d: got %h want %h", instr, i, obs, exp_q[i]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        ctl_t obs;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = observed();
            checks++;
            if (obs !== mk(1, MAR_L)) begin
                errors++;
                $display("FAIL reset_decode_%0d: got %h want %h", i, obs, mk(1, MAR_L));
            end
        end
        rst = 1'b1;
        #1;
        obs = observed();
        checks++;
        if (obs !== mk(1, MAR_L)) begin
            errors++;
            $display("FAIL reset_release_f0: got %h want %h", obs, mk(1, MAR_L));
        end
        @(posedge clk);
        @(negedge clk);
        obs = observed();
        checks++;
        if (obs !== mk(2, IR_L | PC_INC)) begin
            errors++;
            $display("FAIL reset_first_f1: got %h want %h", obs, mk(2, IR_L | PC_INC));
        end
        // ir=0x00 is a NOP: one idle execute cycle, then back to F0.
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_ldi();
        ctl_t obs;
        run_instr(8'h5A, 1'b0, 1'b0);
        obs = observed();
        checks++;
        if (obs !== mk(1, MAR_L)) begin
            errors++;
            $display("FAIL ldi_latency_f0: got %h want %h", obs, mk(1, MAR_L));
        end
    endtask

    task automatic test_add_sub();
        run_instr(8'h23, 1'b0, 1'b0);
        run_instr(8'h33, 1'b1, 1'b0);
        run_instr(8'h17, 1'b0, 1'b1);
        run_instr(8'h4C, 1'b0, 1'b0);
    endtask

    task automatic test_jumps();
        run_instr(8'h74, 1'b0, 1'b1);
        run_instr(8'h74, 1'b1, 1'b0);
        run_instr(8'h84, 1'b0, 1'b1);
        run_instr(8'h84, 1'b1, 1'b0);
        run_instr(8'h63, 1'b0, 1'b0);
        run_instr(8'hE0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] instr;
        for (int n = 0; n < 40; n++) begin
            instr = {$urandom_range(0, 14), $urandom_range(0, 15)}[7:0];
            run_instr(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_halt();
        ctl_t obs;
        run_instr(8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus_if.ir     = 8'($urandom);
            bus_if.flag_c = 1'($urandom_range(0, 1));
            bus_if.flag_z = 1'($urandom_range(0, 1));
            #1;
            obs = observed();
            checks++;
            if (obs !== mk(0, HALTED)) begin
                errors++;
                $display("FAIL halt_hold_%0d: got %h want %h", i, obs, mk(0, HALTED));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        ctl_t obs;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_if.ir = 8'h23;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        obs = observed();
        checks++;
        if (obs !== mk(2, B_L)) begin
            errors++;
            $display("FAIL add_e1_before_reset: got %h want %h", obs, mk(2, B_L));
        end
        rst = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== mk(1, MAR_L)) begin
            errors++;
            $display("FAIL reset_mid_add: got %h want %h", obs, mk(1, MAR_L));
        end
        @(negedge clk);
        rst = 1'b1;
        run_instr(8'h19, 1'b0, 1'b0);
    endtask

`ifdef CTRL_SINGLE_STEP_EN
    task automatic test_single_step();
        ctl_t obs;
        bus_if.step = 1'b0;
        bus_if.ir   = 8'h1B;
        for (int i = 0; i < 5; i++) begin
            #1;
            obs = observed();
            checks++;
            if (obs[10:0] !== 11'h0) begin
                errors++;
                $display("FAIL step_wait_%0d: got %h want enables 000", i, obs[10:0]);
            end
            @(negedge clk);
        end
        build_expect(8'h1B, 1'b0, 1'b0);
        bus_if.step = 1'b1;
        foreach (exp_q[i]) begin
            #1;
            obs = observed();
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL step_lda_%0d: got %h want %h", i, obs, exp_q[i]);
            end
            @(posedge clk);
            @(negedge clk);
            bus_if.step = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = observed();
            checks++;
            if (obs[10:0] !== 11'h0) begin
                errors++;
                $display("FAIL step_rewait_%0d: got %h want enables 000", i, obs[10:0]);
            end
            @(negedge clk);
        end
        bus_if.step = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.ir     = 8'h00;
        bus_if.flag_c = 1'b0;
        bus_if.flag_z = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        bus_if.step   = 1'b1;
`endif
        test_reset();
        test_ldi();
        test_add_sub();
        test_jumps();
        test_random();
`ifdef CTRL_SINGLE_STEP_EN
        test_single_step();
`endif
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
